// File: rtl/hazard_tracker_n.sv
// hazard_tracker_n: in-order multi-lane issue hazard tracker.
// Tracks DEPTH stages of in-flight producers after ID, gates issue on
// load-use hazards and computes operand forwarding selects for stage 0.
module hazard_tracker_n #(
    parameter int LANES = 2,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16,
    localparam int SEL_W = $clog2(1 + LANES * DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       id_valid,
    input  logic [LANES*5-1:0]     id_rs1,
    input  logic [LANES*5-1:0]     id_rs2,
    input  logic [LANES*5-1:0]     id_rd,
    input  logic [LANES-1:0]       id_wb,
    input  logic [LANES-1:0]       id_load,
    input  logic [LANES-1:0]       id_use_rs2,
    input  logic                   flush,
    output logic [LANES-1:0]       issue_mask,
    output logic                   stall,
    output logic [LANES-1:0]       ex_valid,
    output logic [LANES*SEL_W-1:0] fwd_rs1_sel,
    output logic [LANES*SEL_W-1:0] fwd_rs2_sel,
    output logic [CNT_W-1:0]       stall_cnt
);

    // Per-stage producer fields
    logic [LANES-1:0] st_valid [DEPTH];
    logic [LANES-1:0] st_wb    [DEPTH];
    logic [LANES-1:0] st_load  [DEPTH];
    logic [4:0]       st_rd    [DEPTH][LANES];

    // Stage-0 operand fields, needed only for forwarding
    logic [4:0]       s0_rs1   [LANES];
    logic [4:0]       s0_rs2   [LANES];
    logic [LANES-1:0] s0_use2;

    logic [LANES-1:0] blocked;
    logic             issue_ok;

    // A producer feeds an operand only if valid, writing, and not x0
    function automatic logic hit(input logic v, input logic wb,
                                 input logic [4:0] rd, input logic [4:0] idx);
        return v && wb && (rd != 5'd0) && (rd == idx);
    endfunction

    // Load-use detection against stage-0 loads and older loads in the ID group
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (id_valid[i]) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (st_load[0][j] &&
                        (hit(st_valid[0][j], st_wb[0][j], st_rd[0][j], id_rs1[5*i +: 5]) ||
                         (id_use_rs2[i] &&
                          hit(st_valid[0][j], st_wb[0][j], st_rd[0][j], id_rs2[5*i +: 5]))))
                        blocked[i] = 1'b1;
                    if ((j < i) && id_load[j] &&
                        (hit(id_valid[j], id_wb[j], id_rd[5*j +: 5], id_rs1[5*i +: 5]) ||
                         (id_use_rs2[i] &&
                          hit(id_valid[j], id_wb[j], id_rd[5*j +: 5], id_rs2[5*i +: 5]))))
                        blocked[i] = 1'b1;
                end
            end
        end
    end

    // In-order acceptance: the first blocked lane shuts every later lane
    always_comb begin
        issue_mask = '0;
        issue_ok   = reset && !flush;
        for (int unsigned i = 0; i < LANES; i++) begin
            issue_ok      = issue_ok && !blocked[i];
            issue_mask[i] = issue_ok && id_valid[i];
        end
    end

    assign stall    = reset && !flush && (|(id_valid & ~issue_mask));
    assign ex_valid = st_valid[0];

    // Forwarding select: scan oldest to youngest so the youngest match is left
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (st_valid[0][i]) begin
                for (int unsigned t = 1; t < DEPTH; t++) begin
                    for (int unsigned j = 0; j < LANES; j++) begin
                        if (hit(st_valid[DEPTH-t][j], st_wb[DEPTH-t][j], st_rd[DEPTH-t][j], s0_rs1[i]))
                            fwd_rs1_sel[SEL_W*i +: SEL_W] = SEL_W'(1 + (DEPTH - t) * LANES + j);
                        if (s0_use2[i] &&
                            hit(st_valid[DEPTH-t][j], st_wb[DEPTH-t][j], st_rd[DEPTH-t][j], s0_rs2[i]))
                            fwd_rs2_sel[SEL_W*i +: SEL_W] = SEL_W'(1 + (DEPTH - t) * LANES + j);
                    end
                end
                for (int unsigned j = 0; j < LANES; j++) begin
                    if ((j < i) && hit(st_valid[0][j], st_wb[0][j], st_rd[0][j], s0_rs1[i]))
                        fwd_rs1_sel[SEL_W*i +: SEL_W] = SEL_W'(1 + j);
                    if ((j < i) && s0_use2[i] &&
                        hit(st_valid[0][j], st_wb[0][j], st_rd[0][j], s0_rs2[i]))
                        fwd_rs2_sel[SEL_W*i +: SEL_W] = SEL_W'(1 + j);
                end
            end
        end
    end

    // Pipeline advance: stage 0 takes issued lanes, later stages shift every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                st_valid[s] <= '0;
                st_wb[s]    <= '0;
                st_load[s]  <= '0;
                for (int unsigned j = 0; j < LANES; j++)
                    st_rd[s][j] <= '0;
            end
            for (int unsigned j = 0; j < LANES; j++) begin
                s0_rs1[j] <= '0;
                s0_rs2[j] <= '0;
            end
            s0_use2 <= '0;
        end else begin
            st_valid[0] <= issue_mask;
            st_wb[0]    <= id_wb;
            st_load[0]  <= id_load;
            s0_use2     <= id_use_rs2;
            for (int unsigned j = 0; j < LANES; j++) begin
                st_rd[0][j] <= id_rd[5*j +: 5];
                s0_rs1[j]   <= id_rs1[5*j +: 5];
                s0_rs2[j]   <= id_rs2[5*j +: 5];
            end
            for (int unsigned s = 1; s < DEPTH; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_wb[s]    <= st_wb[s-1];
                st_load[s]  <= st_load[s-1];
                for (int unsigned j = 0; j < LANES; j++)
                    st_rd[s][j] <= st_rd[s-1][j];
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: doc/hazard_tracker_n.md
HAZARD_TRACKER_N -- requirements
Module: hazard_tracker_n

Interface
REQ-001 Parameter LANES, default 2, issue width; legal range 1..4.
REQ-002 Parameter DEPTH, default 3, tracked stages after ID (stage 0 = ID/EX); legal range 2..4.
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 Derived SEL_W = $clog2(1+LANES*DEPTH), forwarding-select width.
REQ-005 Clock is clk and reset is reset. Reset is asynchronous and active-low.
REQ-006 Ports, in order:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- id_valid, input, LANES, per-lane valid for the decoded group.
- id_rs1, id_rs2, id_rd, input, LANES*5 each, register indices; lane i occupies bits [5i+4:5i].
- id_wb, input, LANES, lane writes a register.
- id_load, input, LANES, lane is a load.
- id_use_rs2, input, LANES, lane reads rs2.
- flush, input, 1, kill the ID group and stage 0.
- issue_mask, output, LANES, lanes accepted this cycle.
- stall, output, 1, a valid ID lane was not accepted.
- ex_valid, output, LANES, stage-0 lane valid.
- fwd_rs1_sel, fwd_rs2_sel, output, LANES*SEL_W each, stage-0 operand source.
- stall_cnt, output, CNT_W, count of stall cycles.

Function
REQ-007 Each stage s holds per-lane valid, rd, wb and load fields.
REQ-008 Stages s≥1 load from stage s-1 every cycle; there is no hold.
REQ-009 Stage 0 loads the ID fields of lanes in issue_mask; all other lanes load as invalid.
REQ-010 A producer matches an operand only when it is valid, wb=1, rd≠0 and rd equals the operand index; rs2 is ignored when id_use_rs2=0.
REQ-011 Lane i is blocked under either condition:
- a valid ID operand matches a load in stage 0, any lane;
- it matches a load in ID lane k<i that is valid.
REQ-012 issue_mask[i]=1 iff id_valid[i]=1, flush=0, and no lane k≤i is blocked; invalid lanes never block.
REQ-013 issue_mask is combinational from the current inputs and state.
REQ-014 stall=1 iff flush=0 and some valid lane has issue_mask=0.
REQ-015 Upstream re-presents the unissued lanes; this block keeps no ID state.
REQ-016 flush=1 forces issue_mask=0 and clears stage 0 at the next edge; stages ≥1 still advance.
REQ-017 Forwarding select encoding:
- 0 = register file.
- 1+s*LANES+j = stage s, lane j.
REQ-018 For stage-0 lane i, candidate producers are stage-0 lanes j<i and every lane of stages 1..DEPTH-1.
REQ-019 Forwarding priority is youngest first: stage 0 before stage 1 before stage 2, and so on; within a stage the higher lane wins.
REQ-020 fwd_*_sel=0 when stage-0 lane i is invalid or when no candidate matches.
REQ-021 stall_cnt increments on every cycle with stall=1 and saturates at 2^CNT_W-1.
REQ-022 ex_valid is the registered stage-0 valid.

Reset
REQ-023 While reset=0, all stage valids, ex_valid, issue_mask, stall, fwd selects and stall_cnt are 0.
REQ-024 A reset asserted mid-operation discards all in-flight entries at once; the first cycle after release sees empty stages.

Verification (LANES=2, DEPTH=3)
REQ-025 Load-use: cycle t, lane0 lw x5 issues. Cycle t+1, lane0 add rs1=x5 → issue_mask=00, stall=1. Cycle t+2 → issue_mask=01. Cycle t+3 → fwd_rs1_sel[0]=5.
REQ-026 Intra-group ALU: lane0 add rd=x3 and lane1 rs1=x3 → issue_mask=11; the next cycle fwd_rs1_sel[1]=1.
REQ-027 Intra-group load: lane0 lw rd=x3 and lane1 rs2=x3 with use_rs2=1 → issue_mask=01, stall=1. With use_rs2=0 → issue_mask=11.
REQ-028 Priority: both stage-1 lanes write x7 and the stage-0 consumer reads x7 → sel=4. An rd=x0 producer → sel=0.
REQ-029 Flush: stage 0 valid=11 and flush=1 → ex_valid=00 next cycle, issue_mask=00, stall=0, stall_cnt unchanged.
REQ-030 Saturation and reset: with CNT_W=2, 5 stall cycles → stall_cnt=3. Asserting reset mid-stream → all outputs 0 immediately.
